// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-address generator bundle (EX feedback, imem insn, IF register outputs).
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
interface pc_gen_if;
  logic                   cpu_en;
  logic                   pc_stall;
  logic                   ex_redirect_en;
  logic [`PC_WIDTH-1:0]   ex_redirect_pc;
  logic                   bht_upd_en;
  logic [`PC_WIDTH-1:0]   bht_upd_pc;
  logic                   bht_upd_taken;
  logic [`WORD_WIDTH-1:0] insn;
  logic [`PC_WIDTH-1:0]   pc;
  logic                   predt_br_taken;
  logic [`PC_WIDTH-1:0]   next_pc;
  modport master (
    output cpu_en, pc_stall, ex_redirect_en, ex_redirect_pc,
           bht_upd_en, bht_upd_pc, bht_upd_taken, insn,
    input  pc, predt_br_taken, next_pc
  );
  modport slave (
    input  cpu_en, pc_stall, ex_redirect_en, ex_redirect_pc,
           bht_upd_en, bht_upd_pc, bht_upd_taken, insn,
    output pc, predt_br_taken, next_pc
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with predecode and branch/JAL prediction.
// SIICPU_BHT_EN selects a 2-bit BHT; otherwise static backward-taken/forward-not-taken.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
module pc_gen #(
  parameter logic [`PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   BHT_DEPTH = 64,
  parameter int                   BHT_IDX_W = 6
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  logic                 is_br, is_jal, br_pred;
  logic [`PC_WIDTH-1:0] b_imm, j_imm, pred_target;
  assign is_br  = bus.insn[6:0] == 7'b1100011;
  assign is_jal = bus.insn[6:0] == 7'b1101111;
  assign b_imm  = {{(`PC_WIDTH-13){bus.insn[31]}}, bus.insn[31], bus.insn[7],
                   bus.insn[30:25], bus.insn[11:8], 1'b0};
  assign j_imm  = {{(`PC_WIDTH-21){bus.insn[31]}}, bus.insn[31], bus.insn[19:12],
                   bus.insn[20], bus.insn[30:21], 1'b0};
  assign pred_target        = bus.pc + (is_jal ? j_imm : b_imm);
  assign bus.predt_br_taken = is_jal | (is_br & br_pred);
  assign bus.next_pc = bus.ex_redirect_en ? bus.ex_redirect_pc :
                       bus.pc_stall       ? bus.pc :
                       bus.predt_br_taken ? pred_target : bus.pc + `PC_WIDTH'(4);
  always_ff @(posedge clk)
    if (rst) bus.pc <= RESET_PC;
    else if (bus.cpu_en) bus.pc <= bus.next_pc;
`ifdef SIICPU_BHT_EN
  logic [1:0]           bht [BHT_DEPTH];
  logic [1:0]           ctr, upd_ctr;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_upd;
  assign ctr        = bht[bus.pc[BHT_IDX_W+1:2]];
  assign upd_idx    = bus.bht_upd_pc[BHT_IDX_W+1:2];
  assign upd_ctr    = bht[upd_idx];
  assign br_pred    = ctr[1];
  assign unused_upd = ^{bus.bht_upd_pc[`PC_WIDTH-1:BHT_IDX_W+2], bus.bht_upd_pc[1:0]};
  // Lookup reads the pre-update counter; a same-cycle write lands next cycle.
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    else if (bus.cpu_en && bus.bht_upd_en)
      bht[upd_idx] <= bus.bht_upd_taken ? (upd_ctr == 2'b11 ? upd_ctr : upd_ctr + 2'd1)
                                        : (upd_ctr == 2'b00 ? upd_ctr : upd_ctr - 2'd1);
`else
  logic unused_upd;
  assign br_pred    = b_imm[`PC_WIDTH-1];
  assign unused_upd = ^{bus.bht_upd_en, bus.bht_upd_pc, bus.bht_upd_taken};
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test-plan scenarios plus randomized traffic against a fetch-PC reference model.
module tb_pc_gen;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b0;
  pc_gen_if bus();
  pc_gen #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ctr_m [64];
  logic [31:0] pc_m;
  bit          pc_known = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] i;
    i = 13'(off);
    return {i[12], i[10:5], 5'($urandom), 5'($urandom), 3'($urandom), i[4:1], i[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] i;
    i = 21'(off);
    return {i[20], i[10:1], i[11], i[19:12], 5'($urandom), 7'b1101111};
  endfunction
  function automatic logic [31:0] rand_other();
    logic [6:0]  ops [6];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0110011, 7'b1100111, 7'b0000011, 7'b0100011, 7'b0110111};
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 5)];
    return r;
  endfunction
  // kind: 0 = not predictable, 1 = conditional branch, 2 = JAL; off is the encoded offset
  task automatic cycle(input logic [31:0] insn, input int kind, input int off, input bit en,
                       input bit stall, input bit redir, input logic [31:0] rpc, input bit upd,
                       input logic [31:0] upc, input bit ut, input bit r);
    bit          exp_pred;
    logic [31:0] exp_next;
    exp_next = 'x;
    @(negedge clk);
    rst = r; bus.insn = insn; bus.cpu_en = en; bus.pc_stall = stall;
    bus.ex_redirect_en = redir; bus.ex_redirect_pc = rpc;
    bus.bht_upd_en = upd; bus.bht_upd_pc = upc; bus.bht_upd_taken = ut;
    #1;
    if (pc_known) begin
`ifdef SIICPU_BHT_EN
      exp_pred = kind == 2 || (kind == 1 && ctr_m[int'((pc_m >> 2) % 64)] >= 2);
`else
      exp_pred = kind == 2 || (kind == 1 && off < 0);
`endif
      exp_next = redir ? rpc : stall ? pc_m : exp_pred ? pc_m + 32'(off) : pc_m + 32'd4;
      check("pc", bus.pc, pc_m);
      check("predt_br_taken", {31'b0, bus.predt_br_taken}, {31'b0, exp_pred});
      check("next_pc", bus.next_pc, exp_next);
    end
    @(posedge clk);
    if (r) begin
      pc_m = RESET_PC;
      pc_known = 1;
      foreach (ctr_m[i]) ctr_m[i] = 1;
    end else if (en) begin
      pc_m = exp_next;
`ifdef SIICPU_BHT_EN
      if (upd) begin
        int ix;
        ix = int'((upc >> 2) % 64);
        ctr_m[ix] = ut ? (ctr_m[ix] < 3 ? ctr_m[ix] + 1 : 3) : (ctr_m[ix] > 0 ? ctr_m[ix] - 1 : 0);
      end
`endif
    end
  endtask
  task automatic run(input logic [31:0] insn, input int kind, input int off);
    cycle(insn, kind, off, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic go(input logic [31:0] target);
    cycle(NOP, 0, 0, 1, 0, 1, target, 0, 0, 0, 0);
  endtask
  task automatic train(input logic [31:0] insn, input int off, input logic [31:0] upc, input bit ut);
    cycle(insn, 1, off, 1, 1, 0, 0, 1, upc, ut, 0);
  endtask
  task automatic expect_pc(input string tag, input logic [31:0] val);
    #1 check(tag, bus.pc, val);
  endtask
  initial begin
    bus.insn = NOP; bus.cpu_en = 0; bus.pc_stall = 0; bus.ex_redirect_en = 0;
    bus.ex_redirect_pc = 0; bus.bht_upd_en = 0; bus.bht_upd_pc = 0; bus.bht_upd_taken = 0;
    cycle(NOP, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    expect_pc("reset_pc", 32'h0);
    repeat (3) run(NOP, 0, 0);
    expect_pc("seq_pc", 32'hC);
    go(32'h10);
    run(32'h0200_006F, 2, 32'h20);
    expect_pc("jal_pc", 32'h30);
    // beq +8 at 0x40: update and lookup hit the same counter in one cycle
    go(32'h40);
    train(32'h0000_0463, 8, 32'h40, 1);
    run(32'h0000_0463, 1, 8);
`ifdef SIICPU_BHT_EN
    expect_pc("bht_trained_pc", 32'h48);
`else
    expect_pc("static_fwd_pc", 32'h44);
`endif
    go(32'h40);
    repeat (3) train(32'h0000_0463, 8, 32'h40, 1);
    train(32'h0000_0463, 8, 32'h40, 0);
    run(32'h0000_0463, 1, 8);
    go(32'h80);
    run(enc_b(-8), 1, -8);
`ifdef SIICPU_BHT_EN
    expect_pc("bht_back_pc", 32'h84);
`else
    expect_pc("static_back_pc", 32'h78);
`endif
    go(32'h100);
    cycle(NOP, 0, 0, 1, 1, 1, 32'h200, 0, 0, 0, 0);
    expect_pc("redir_over_stall", 32'h200);
    cycle(NOP, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    expect_pc("stall_hold", 32'h200);
    go(32'hFFFF_FFFC);
    run(NOP, 0, 0);
    expect_pc("wrap_pc", 32'h0);
    cycle(NOP, 0, 0, 0, 0, 1, 32'h500, 1, 32'h0, 1, 0);
    expect_pc("cpu_en_hold", 32'h0);
    go(32'h300);
    cycle(NOP, 0, 0, 1, 0, 1, 32'h700, 1, 32'h300, 1, 1);
    expect_pc("reset_over_redir", RESET_PC);
    for (int k = 0; k < 3000; k++) begin
      int          sel, off, kind;
      logic [31:0] ins, rpc, upc;
      sel = $urandom_range(0, 9);
      off = 0;
      kind = 0;
      if (sel < 4) begin
        off = int'($urandom_range(0, 4095)) * 2 - 4096;
        ins = enc_b(off);
        kind = 1;
      end else if (sel < 6) begin
        off = int'($urandom_range(0, 1048575)) * 2 - 1048576;
        ins = enc_j(off);
        kind = 2;
      end else ins = rand_other();
      rpc = $urandom_range(0, 7) == 0 ? $urandom() : 32'($urandom_range(0, 1023)) * 4;
      upc = $urandom_range(0, 1) == 0 ? pc_m : $urandom();
      cycle(ins, kind, off, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, rpc, $urandom_range(0, 2) == 0, upc,
            $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-address generator; sits directly upstream of the IF pipeline register.
- Holds the architectural fetch PC and drives it to instruction memory.
- Predecodes the instruction returned combinationally for the current PC, predicts branch/JAL direction and target, and computes the next PC.
- Presents pc and predt_br_taken to the IF register. Accepts redirects and branch-outcome updates from EX.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- BHT_DEPTH, 64, number of 2-bit branch history counters; power of two, ≥2.
- BHT_IDX_W, 6, log2(BHT_DEPTH); index = pc[BHT_IDX_W+1:2].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cpu_en  in  1  global enable; when low, all state holds.
- pc_stall  in  1  hold current PC (hazard/memory wait).
- ex_redirect_en  in  1  EX detected misprediction or trap; redirect fetch.
- ex_redirect_pc  in  `PC_WIDTH  corrected fetch address.
- bht_upd_en  in  1  EX resolved a conditional branch.
- bht_upd_pc  in  `PC_WIDTH  PC of the resolved branch.
- bht_upd_taken  in  1  actual branch outcome.
- insn  in  `WORD_WIDTH  instruction at pc (combinational from imem).
- pc  out  `PC_WIDTH  current fetch address (registered).
- predt_br_taken  out  1  current insn predicted taken (combinational).
- next_pc  out  `PC_WIDTH  address to be loaded next cycle (combinational; for imem prefetch).

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - pc <= RESET_PC.
  - All BHT counters <= 2'b01 (weakly not-taken).
  - rst has priority over cpu_en.
- Predecode (combinational on insn):
  - is_br: opcode==7'b1100011.
  - is_jal: opcode==7'b1101111.
  - B-imm and J-imm are sign-extended to `PC_WIDTH.
  - JALR and all other opcodes are never predicted.
- Prediction:
  - ctr = BHT[pc[BHT_IDX_W+1:2]].
  - predt_br_taken = is_jal | (is_br & ctr[1]).
  - pred_target = pc + (is_jal ? J-imm : B-imm).
- next_pc priority, highest first:
  1. ex_redirect_en → ex_redirect_pc.
  2. pc_stall → pc.
  3. predt_br_taken → pred_target.
  4. otherwise → pc+4.
- Update rules:
  - pc <= next_pc on each posedge with cpu_en=1 and rst=0. Latency: redirect visible on pc exactly 1 cycle after ex_redirect_en.
  - A redirect overrides a simultaneous stall.
  - Arithmetic is modulo 2^`PC_WIDTH; pc+4 at 32'hFFFF_FFFC wraps to 0.
  - No alignment check; targets pass through unmodified.
- BHT update, on posedge with cpu_en=1 and bht_upd_en=1:
  - Counter at bht_upd_pc[BHT_IDX_W+1:2] increments if taken, decrements otherwise.
  - Saturates at 2'b11 and 2'b00; no wrap.
- Simultaneous BHT update and lookup of the same index: lookup uses the pre-update value. There is no bypass; the new value is seen from the next cycle.
- BHT update is independent of pc_stall and ex_redirect_en. An update arriving with a redirect is still applied.
- cpu_en=0: pc and BHT hold; combinational outputs still track insn.
- Reset asserted mid-operation discards any pending redirect or update in that cycle.

Optional Feature:
- Macro: SIICPU_BHT_EN.
- Defined: dynamic BHT prediction exactly as above.
- Not defined:
  - No counter storage.
  - bht_upd_* inputs are ignored.
  - Static backward-taken/forward-not-taken: predt_br_taken = is_jal | (is_br & B-imm sign bit).
  - All other behaviour is identical.

Test Plan:
- Reset/sequential fetch: rst=1 for 1 cycle, RESET_PC=0, insn=NOP (32'h00000013) → pc sequence 0,4,8,C; predt_br_taken=0.
- JAL prediction: pc=0x10, insn=JAL +0x20 (32'h0200006F) → predt_br_taken=1, next_pc=0x30, pc=0x30 next cycle.
- BHT training (SIICPU_BHT_EN), beq +8 at 0x40:
  - Initially → not taken, next_pc=0x44.
  - After one update taken=1 → counter 2'b10, predicts taken, next_pc=0x48.
  - After 3 more taken updates → counter stays 2'b11.
- Redirect vs stall: pc=0x100, pc_stall=1, ex_redirect_en=1, ex_redirect_pc=0x200 → pc=0x200 next cycle. Stall alone → pc holds 0x100.
- Same-index update/lookup: counter 2'b01, bht_upd_taken=1 to 0x40 while pc=0x40 with beq → that cycle predicts not-taken; next lookup predicts taken.
- Static mode (macro undefined): beq −8 at 0x80 → taken, next_pc=0x78. beq +8 → next_pc=0x84. bht_upd_en pulses have no effect.
